// File: rtl/lf_ctrl_pkg.sv
// Shared gear/state codes for the ADPLL loop-filter gain scheduler.
package lf_ctrl_pkg;

  typedef enum logic [1:0] {
    GEAR_IDLE = 2'b00,
    GEAR_ACQ  = 2'b01,
    GEAR_TRK  = 2'b10,
    GEAR_LCK  = 2'b11
  } gear_t;

endpackage

// File: rtl/lf_run_counter.sv
// Saturating run-length counter: counts consecutive cycles with evt high,
// restarts on a miss or clear, and flags when LIMIT-1 prior hits are banked.
module lf_run_counter #(
  parameter int LIMIT = 16
) (
  input  logic gen_clk_i,
  input  logic reset_i,
  input  logic evt,
  input  logic clear,
  output logic terminal
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(LIMIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge gen_clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt <= '0;
    end else if (clear || !evt) begin
      cnt <= '0;
    end else if (cnt != TERM) begin
      cnt <= cnt + CW'(1);
    end
  end

  // High means the current hit is the LIMIT-th in a row.
  assign terminal = (cnt == TERM);

endmodule

// File: rtl/lf_gear_ctrl.sv
// Gain-scheduling controller stepping the loop filter through ACQ/TRK/LCK.
// Optional LF_GEAR_HOLD_EN: freeze run counters for HOLDOFF cycles after each shift.
module lf_gear_ctrl
  import lf_ctrl_pkg::*;
#(
  parameter int                  ERROR_WIDTH  = 5,
  parameter int                  KP_WIDTH     = 5,
  parameter int                  KI_WIDTH     = 7,
  parameter logic [KP_WIDTH-1:0] KP_ACQ       = 5'd8,
  parameter logic [KI_WIDTH-1:0] KI_ACQ       = 7'd16,
  parameter logic [KP_WIDTH-1:0] KP_TRK       = 5'd4,
  parameter logic [KI_WIDTH-1:0] KI_TRK       = 7'd4,
  parameter logic [KP_WIDTH-1:0] KP_LCK       = 5'd1,
  parameter logic [KI_WIDTH-1:0] KI_LCK       = 7'd1,
  parameter int                  LOCK_THRESH  = 2,
  parameter int                  WINDOW       = 16,
  parameter int                  UNLOCK_COUNT = 4,
  parameter int                  HOLDOFF      = 8
) (
  input  logic                   gen_clk_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic [ERROR_WIDTH-1:0] error_i,
  output logic [KP_WIDTH-1:0]    kp_o,
  output logic [KI_WIDTH-1:0]    ki_o,
  output logic [1:0]             gear_o,
  output logic                   lock_o,
  output logic                   gear_change_o
);

  if (WINDOW < 2 || UNLOCK_COUNT < 1 || HOLDOFF < 0) begin : g_bad_param
    $error("lf_gear_ctrl: WINDOW must be >= 2, UNLOCK_COUNT >= 1, HOLDOFF >= 0");
  end

  localparam logic [ERROR_WIDTH:0] THRESH = (ERROR_WIDTH + 1)'(LOCK_THRESH);

  gear_t                   state, state_n;
  logic signed [ERROR_WIDTH:0] err_ext;
  logic [ERROR_WIDTH:0]    err_mag;
  logic                    in_band;
  logic                    state_chg;
  logic                    count_blk;
  logic                    cnt_clear;
  logic                    good_term;
  logic                    bad_term;

  // Extra sign bit so the most negative code gets its true magnitude.
  assign err_ext = {error_i[ERROR_WIDTH-1], error_i};
  assign err_mag = err_ext[ERROR_WIDTH] ? $unsigned(-err_ext) : $unsigned(err_ext);
  assign in_band = (err_mag <= THRESH);

`ifdef LF_GEAR_HOLD_EN
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF);

  logic [HW-1:0] hold_cnt;

  always_ff @(posedge gen_clk_i or posedge reset_i) begin
    if (reset_i) begin
      hold_cnt <= '0;
    end else if (state_chg) begin
      hold_cnt <= (state_n == GEAR_IDLE) ? '0 : HOLD_INIT;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - HW'(1);
    end
  end

  assign count_blk = (hold_cnt != '0);
`else
  assign count_blk = 1'b0;
`endif

  assign state_chg = (state_n != state);
  assign cnt_clear = state_chg || count_blk || (state == GEAR_IDLE);

  lf_run_counter #(.LIMIT(WINDOW)) u_good_cnt (
    .gen_clk_i (gen_clk_i),
    .reset_i   (reset_i),
    .evt       (in_band),
    .clear     (cnt_clear),
    .terminal  (good_term)
  );

  lf_run_counter #(.LIMIT(UNLOCK_COUNT)) u_bad_cnt (
    .gen_clk_i (gen_clk_i),
    .reset_i   (reset_i),
    .evt       (!in_band),
    .clear     (cnt_clear),
    .terminal  (bad_term)
  );

  always_ff @(posedge gen_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= GEAR_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (!enable_i) begin
      state_n = GEAR_IDLE;
    end else begin
      case (state)
        GEAR_IDLE: state_n = GEAR_ACQ;
        GEAR_ACQ: begin
          if (!count_blk && in_band && good_term) state_n = GEAR_TRK;
        end
        GEAR_TRK: begin
          if (!count_blk && in_band && good_term) state_n = GEAR_LCK;
          else if (!count_blk && !in_band && bad_term) state_n = GEAR_ACQ;
        end
        GEAR_LCK: begin
          // Fall back all the way to ACQ, never one gear at a time.
          if (!count_blk && !in_band && bad_term) state_n = GEAR_ACQ;
        end
        default: state_n = GEAR_IDLE;
      endcase
    end
  end

  // Outputs follow the next state so they change on the same edge as state.
  always_ff @(posedge gen_clk_i or posedge reset_i) begin
    if (reset_i) begin
      kp_o          <= KP_ACQ;
      ki_o          <= KI_ACQ;
      gear_o        <= GEAR_IDLE;
      lock_o        <= 1'b0;
      gear_change_o <= 1'b0;
    end else begin
      gear_o        <= state_n;
      lock_o        <= (state_n == GEAR_LCK);
      gear_change_o <= state_chg;
      case (state_n)
        GEAR_TRK: begin
          kp_o <= KP_TRK;
          ki_o <= KI_TRK;
        end
        GEAR_LCK: begin
          kp_o <= KP_LCK;
          ki_o <= KI_LCK;
        end
        default: begin
          kp_o <= KP_ACQ;
          ki_o <= KI_ACQ;
        end
      endcase
    end
  end

endmodule

// File: doc/lf_gear_ctrl.md
Name: lf_gear_ctrl

Overview:
- Gain-scheduling ("gear-shift") controller for the ADPLL loop filter.
- Watches the phase-error stream and steps the loop through three gear states: acquire, track and locked.
- Drives the loop filter's runtime kp/ki inputs; the filter runs in dynamic-gain mode.
- Raises a lock flag and falls back to acquire on sustained error.

Parameters:
- ERROR_WIDTH, 5, width of signed phase error.
- KP_WIDTH, 5, kp output width.
- KI_WIDTH, 7, ki output width.
- KP_ACQ / KI_ACQ, 5'd8 / 7'd16, acquire gains.
- KP_TRK / KI_TRK, 5'd4 / 7'd4, track gains.
- KP_LCK / KI_LCK, 5'd1 / 7'd1, locked gains.
- LOCK_THRESH, 2, in-band limit; sample is in band when |error| <= LOCK_THRESH.
- WINDOW, 16, consecutive in-band samples needed to shift up one gear (>=2).
- UNLOCK_COUNT, 4, consecutive out-of-band samples needed to fall back (>=1).
- HOLDOFF, 8, settle cycles after a shift; used only with the optional feature.

Ports:
- gen_clk_i  in  1  loop clock; error sampled every rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  run controller; low forces IDLE.
- error_i  in  ERROR_WIDTH  signed phase error.
- kp_o  out  KP_WIDTH  proportional gain to loop filter.
- ki_o  out  KI_WIDTH  integral gain to loop filter.
- gear_o  out  2  current state code.
- lock_o  out  1  high only in LCK.
- gear_change_o  out  1  one-cycle pulse after any gear change.

Behaviour:
- States and codes: IDLE=00, ACQ=01, TRK=10, LCK=11. All outputs are registered.
- Reset: state IDLE; kp_o=KP_ACQ, ki_o=KI_ACQ; gear_o=00; lock_o=0; gear_change_o=0; all counters 0.
- In-band test: error_i is sign-extended by 1 bit before abs(). The most negative code (-16 at width 5) therefore has magnitude 16 and is out of band.
- good_cnt: counts consecutive in-band samples, saturating at WINDOW-1.
  - Cleared on any out-of-band sample and on any state change.
- bad_cnt: counts consecutive out-of-band samples, saturating at UNLOCK_COUNT-1.
  - Cleared on any in-band sample and on any state change.
- Transitions, evaluated at each edge:
  - IDLE -> ACQ when enable_i=1.
  - ACQ -> TRK when in band and good_cnt==WINDOW-1, i.e. the WINDOW-th consecutive in-band sample.
  - TRK -> LCK under the same rule.
  - TRK or LCK -> ACQ when out of band and bad_cnt==UNLOCK_COUNT-1. The fall-back goes straight to ACQ, never one gear at a time.
  - Any state -> IDLE when enable_i=0. This has priority over all other transitions.
  - Out-of-band samples in ACQ only clear good_cnt.
- Gains: kp_o/ki_o/gear_o/lock_o are updated on the same edge as the state register. Values are: IDLE/ACQ use ACQ gains, TRK uses TRK gains, LCK uses LCK gains.
- gear_change_o: high for exactly the one cycle following an edge where the state changed. This includes IDLE->ACQ and ->IDLE.
- Latency: in-band samples at edges k..k+WINDOW-1 give new gains visible immediately after edge k+WINDOW-1.
- Asynchronous reset mid-shift: all state and outputs return to reset values immediately; any partial count is discarded.

Optional Feature:
- Macro LF_GEAR_HOLD_EN.
- Defined:
  - After each transition into ACQ/TRK/LCK, a hold counter blocks good_cnt and bad_cnt (both held at 0) for HOLDOFF cycles. This lets the filter integrator settle.
  - enable_i=0 still forces IDLE immediately.
- Undefined: counting starts on the first edge after a transition, and the HOLDOFF parameter is ignored.

Decomposition:
- Package lf_ctrl_pkg holds:
  - the state/gear code constants (IDLE, ACQ, TRK, LCK);
  - the 2-bit gear type.
- One sub-module, lf_run_counter: a saturating consecutive-event counter.
  - Inputs: event, clear. Output: terminal flag.
  - Parameter: LIMIT.
  - Instantiated twice, for good_cnt and bad_cnt.

Test Plan:
- Reset then enable_i=1, error_i=0 constant:
  - gear 01 after 1 edge, 10 after 16 more, 11 after 16 more;
  - kp_o 8->4->1;
  - lock_o=1 at LCK;
  - gear_change_o pulses 3 times, 1 cycle each.
- In ACQ: 15 in-band samples, then error_i=3, then 16 in-band samples -> still ACQ until the 16th sample after the 3, then TRK.
- In LCK: error_i=+5 for 3 cycles then 0 -> stays LCK. Error_i=+5 for 4 cycles -> ACQ, kp_o=8, lock_o=0.
- error_i=-16 (5'b10000) held in LCK for 4 cycles -> falls back to ACQ, confirming the abs-overflow case.
- enable_i dropped in TRK mid-window -> IDLE next edge, gear_o=00, kp_o=8. Re-enable -> ACQ with counters cleared.
- reset_i pulsed asynchronously between edges in LCK -> outputs at reset values before the next edge. With LF_GEAR_HOLD_EN, after the ACQ->TRK shift, 8 cycles of error_i=+5 cause no fall-back.
